// File: rtl/rgb_stream_reader.sv
// rgb_stream_reader: streams packed RGB pixel pairs from SRAM through a word FIFO into a valid/ready pixel output
module rgb_stream_reader #(
    parameter int BASE_ADDR  = 146944,
    parameter int NUM_PIXELS = 76800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic [7:0]  Pixel_R,
    output logic [7:0]  Pixel_G,
    output logic [7:0]  Pixel_B,
    output logic        Pixel_valid,
    input  logic        Pixel_ready,
    output logic        Busy,
    output logic        Done
);
    localparam int NUM_WORDS = NUM_PIXELS * 3 / 2;
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [17:0]     addr_q, addr_d;
    logic [17:0]     word_cnt_q, word_cnt_d;
    logic [17:0]     pix_cnt_q, pix_cnt_d;
    logic [2:0]      tag_q, tag_d;
    logic [15:0]     fifo_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      phase_q, phase_d;
    logic [15:0]     hold_q, hold_d;
    logic [23:0]     pix_q, pix_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            push, pop, hs, last_hs, issue, room;
    logic [OW-1:0]   outstanding;
    logic [15:0]     w;

    // Read issue, FIFO bookkeeping, unpacking and frame control
    always_comb begin
        w           = fifo_q[rd_ptr_q];
        push        = tag_q[2];
        pop         = count_q != '0 && (phase_q == 2'd0 || !valid_q || Pixel_ready);
        hs          = valid_q && Pixel_ready;
        last_hs     = hs && pix_cnt_q == 18'(NUM_PIXELS - 1);
        // a word popped this edge frees its slot, so full read throughput is kept
        outstanding = OW'(count_q) + OW'(tag_q[0]) + OW'(tag_q[1]) + OW'(tag_q[2]) - OW'(pop);
        room        = outstanding < OW'(FIFO_DEPTH);
        issue       = (state_q == IDLE && Start) ||
                      (state_q == RUN && word_cnt_q < 18'(NUM_WORDS) && room);
        addr_d      = !issue ? addr_q : state_q == IDLE ? 18'(BASE_ADDR) : 18'(BASE_ADDR) + word_cnt_q;
        word_cnt_d  = !issue ? word_cnt_q : state_q == IDLE ? 18'd1 : word_cnt_q + 18'd1;
        state_d     = state_q == IDLE ? (Start ? RUN : IDLE) :
                      state_q == RUN ? (issue && word_cnt_q == 18'(NUM_WORDS - 1) ? DRAIN : RUN) :
                      (last_hs ? IDLE : DRAIN);
        pix_cnt_d   = state_q == IDLE ? '0 : pix_cnt_q + 18'(hs);
        done_d      = state_q == DRAIN && last_hs;
        tag_d       = {tag_q[1:0], issue};
        wr_ptr_d    = !push ? wr_ptr_q : wr_ptr_q == AW'(FIFO_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d    = !pop ? rd_ptr_q : rd_ptr_q == AW'(FIFO_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
        count_d     = count_q + CW'(push) - CW'(pop);
        phase_d     = !pop ? phase_q : phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1;
        hold_d      = pop && phase_q != 2'd2 ? w : hold_q;
        pix_d       = pop && phase_q == 2'd1 ? {hold_q, w[15:8]} :
                      pop && phase_q == 2'd2 ? {hold_q[7:0], w} : pix_q;
        valid_d     = pop && phase_q != 2'd0 ? 1'b1 : hs ? 1'b0 : valid_q;
    end

    // State registers; reset clears in-flight tags so late read data is dropped
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            word_cnt_q <= '0;
            pix_cnt_q  <= '0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            phase_q    <= '0;
            hold_q     <= '0;
            pix_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            pix_q      <= pix_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            if (push) fifo_q[wr_ptr_q] <= SRAM_read_data;
        end
    end

    assign SRAM_address = addr_q;
    assign SRAM_we_n    = 1'b1;
    assign Pixel_R      = pix_q[23:16];
    assign Pixel_G      = pix_q[15:8];
    assign Pixel_B      = pix_q[7:0];
    assign Pixel_valid  = valid_q;
    assign Busy         = state_q != IDLE;
    assign Done         = done_q;
endmodule
